// File: rtl/demux14_pkg.sv
// demux14_pkg: shared constants and round-robin pick helper for the 1-to-4 dispatcher
package demux14_pkg;
  localparam int NCH = 4;
  localparam logic MODE_RR = 1'b0;
  localparam logic MODE_FIX = 1'b1;
  function automatic logic [2:0] rr_pick(input logic [3:0] free, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = {1'b0, ptr};
    // scan from the farthest offset down so the nearest free channel wins
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (free[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction
endpackage

// File: rtl/demux14_chan_reg.sv
// demux14_chan_reg: one-entry channel holding register with load/drain handshake
module demux14_chan_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] z,
  output logic             v
);
  // a load wins over a drain so a channel can refill every cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      z <= '0;
      v <= 1'b0;
    end else if (load) begin
      z <= d;
      v <= 1'b1;
    end else if (drain) v <= 1'b0;
endmodule

// File: rtl/demux14_scheduler.sv
// demux14_scheduler: valid/ready dispatch of one input stream into four holding registers
module demux14_scheduler
  import demux14_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] c,
  input  logic             valid,
  output logic             ready,
  input  logic             mode,
  input  logic [1:0]       sel,
  output logic             s0,
  output logic             s1,
  output logic [WIDTH-1:0] z0,
  output logic [WIDTH-1:0] z1,
  output logic [WIDTH-1:0] z2,
  output logic [WIDTH-1:0] z3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  input  logic             r3,
  output logic [CNT_W-1:0] cnt
);
  logic [1:0] ptr, target;
  logic [3:0] v, r, free, load;
  logic [2:0] pick;
  logic accept;
  logic [WIDTH-1:0] z [NCH];
  assign r = {r3, r2, r1, r0};
  assign free = ~v | r;
  assign pick = rr_pick(free, ptr);
  assign target = (mode == MODE_FIX) ? sel : pick[1:0];
  assign ready = (mode == MODE_FIX) ? free[sel] : pick[2];
  assign accept = valid & ready;
  assign {s1, s0} = target;
  assign {v3, v2, v1, v0} = v;
  assign z0 = z[0];
  assign z1 = z[1];
  assign z2 = z[2];
  assign z3 = z[3];
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign load[k] = accept & (target == 2'(k));
    demux14_chan_reg #(.WIDTH(WIDTH)) u_chan (
      .clk(clk), .rst_n(rst_n), .load(load[k]), .drain(r[k]), .d(c), .z(z[k]), .v(v[k])
    );
  end
  // fixed mode leaves the round-robin pointer where it was
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
      if (mode == MODE_RR) ptr <= target + 2'd1;
    end
endmodule

// File: tb/tb_demux14_scheduler.sv
// tb_demux14_scheduler: directed checks of selection, buffering, counter and reset
module tb_demux14_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, c = 1'b0, valid = 1'b0, mode = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [3:0] r = 4'hf;
  logic ready, s0, s1, z0, z1, z2, z3, v0, v1, v2, v3;
  logic [7:0] cnt;
  logic [3:0] vv, zz;
  logic [1:0] s;
  int total = 0, fails = 0;
  int t2 [9] = '{0, 1, 2, 3, 0, 2, 3, 0, 2};
  logic [7:0] pat = 8'b01001101;
  assign vv = {v3, v2, v1, v0};
  assign zz = {z3, z2, z1, z0};
  assign s = {s1, s0};
  always #5 clk = ~clk;
  demux14_scheduler dut (
    .clk(clk), .rst_n(rst_n), .c(c), .valid(valid), .ready(ready), .mode(mode), .sel(sel),
    .s0(s0), .s1(s1), .z0(z0), .z1(z1), .z2(z2), .z3(z3), .v0(v0), .v1(v1), .v2(v2), .v3(v3),
    .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]), .cnt(cnt)
  );
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_v", vv, 0);
    chk("rst_z", zz, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ready", ready, 1);
    chk("rst_sel", s, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1;
      c = pat[i];
      #1;
      chk("rr_sel", s, i % 4);
      chk("rr_ready", ready, 1);
      tick();
      chk("rr_v", vv[i % 4], 1);
      chk("rr_z", zz[i % 4], pat[i]);
    end
    valid = 1'b0;
    chk("rr_cnt", cnt, 8);
    tick();
    chk("rr_drained", vv, 0);
    r = 4'b1101;
    for (int i = 0; i < 9; i++) begin
      valid = 1'b1;
      c = (i == 1);
      #1;
      chk("skip_sel", s, t2[i]);
      tick();
      if (i >= 1) begin
        chk("skip_z1", z1, 1);
        chk("skip_v1", v1, 1);
      end
    end
    valid = 1'b0;
    chk("skip_cnt", cnt, 17);
    tick();
    chk("skip_hold", vv, 4'b0010);
    r = 4'b0000;
    valid = 1'b1;
    c = 1'b1;
    #1;
    chk("fill_sel3", s, 3);
    tick();
    #1;
    chk("fill_sel0", s, 0);
    tick();
    #1;
    chk("fill_sel2", s, 2);
    tick();
    chk("fill_v", vv, 4'hf);
    chk("fill_cnt", cnt, 20);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("busy_ready", ready, 0);
      chk("busy_sel", s, 3);
      tick();
    end
    chk("busy_cnt", cnt, 20);
    r = 4'b1000;
    c = 1'b0;
    #1;
    chk("r3_ready", ready, 1);
    chk("r3_sel", s, 3);
    tick();
    chk("r3_z", z3, 0);
    chk("r3_v", v3, 1);
    chk("r3_cnt", cnt, 21);
    r = 4'b0000;
    #1;
    chk("r3_ptr", s, 0);
    chk("r3_busy", ready, 0);
    mode = 1'b1;
    sel = 2'd2;
    r = 4'b0100;
    c = 1'b1;
    #1;
    chk("fix_ready_a", ready, 1);
    chk("fix_sel_a", s, 2);
    tick();
    chk("fix_z_a", z2, 1);
    chk("fix_cnt_a", cnt, 22);
    r = 4'b0000;
    c = 1'b0;
    #1;
    chk("fix_ready_b", ready, 0);
    chk("fix_sel_b", s, 2);
    tick();
    chk("fix_z_b", z2, 1);
    chk("fix_cnt_b", cnt, 22);
    r = 4'b0100;
    #1;
    chk("fix_ready_c", ready, 1);
    tick();
    chk("fix_z_c", z2, 0);
    chk("fix_v", vv, 4'hf);
    chk("fix_cnt_c", cnt, 23);
    mode = 1'b0;
    r = 4'b0000;
    #1;
    chk("fix_ptr", s, 0);
    chk("fix_rr_ready", ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_v", vv, 0);
    chk("mid_rst_z", zz, 0);
    chk("mid_rst_cnt", cnt, 0);
    tick();
    r = 4'hf;
    valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", ready, 1);
    chk("post_rst_sel", s, 0);
    valid = 1'b1;
    c = 1'b1;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 254) chk("wrap_255", cnt, 255);
    end
    chk("wrap_0", cnt, 0);
    chk("wrap_ptr", s, 0);
    mode = 1'b1;
    sel = 2'd0;
    c = 1'b1;
    tick();
    chk("refill_v_a", v0, 1);
    chk("refill_z_a", z0, 1);
    c = 1'b0;
    tick();
    chk("refill_v_b", v0, 1);
    chk("refill_z_b", z0, 0);
    chk("refill_cnt", cnt, 2);
    valid = 1'b0;
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/demux14_scheduler.md
Name: demux14_scheduler

Overview:
Sequencing controller for the 1-to-4 de-selector datapath. It accepts a single input stream under a valid/ready handshake and dispatches each word to one of four output channels. Each channel has a one-entry holding register with its own valid/ready handshake. Target selection is either round-robin (skipping busy channels) or fixed by a software select; the chosen channel is also driven onto select lines for an external de-selector.

Parameters:
WIDTH, 1, data word width of iC and oZ0..oZ3
CNT_W, 8, width of the dispatch counter oCnt

Ports:
iCLK  input  1  clock, all state updates on rising edge
iRST_N  input  1  asynchronous active-low reset
iC  input  WIDTH  input data word
iValid  input  1  input word present
oReady  output  1  input word accepted this cycle when iValid & oReady
iMode  input  1  0 = round-robin, 1 = fixed channel
iSel  input  2  fixed target channel (used when iMode=1); iSel[0]=S0, iSel[1]=S1
oS0  output  1  select bit 0 of current target (to de-selector)
oS1  output  1  select bit 1 of current target
oZ0..oZ3  output  WIDTH each  channel holding-register data
oV0..oV3  output  1 each  channel holding register valid
iR0..iR3  input  1 each  channel consumer ready
oCnt  output  CNT_W  total words dispatched, wraps

Behaviour:
- Reset (iRST_N low, asynchronous): oV0..3=0, oZ0..3=0, round-robin pointer=0, oCnt=0. oReady evaluates from the cleared state (and current inputs) per the combinational rules below; it is not held low by reset.
- Channel k is "free" this cycle when ~oVk | iRk (empty, or draining this cycle).
- Channel drain: oVk & iRk -> oVk clears next edge unless refilled in the same cycle.
- Target selection, combinational each cycle:
  - iMode=1: target = iSel; oReady = free[iSel].
  - iMode=0: scan channels ptr, ptr+1, ptr+2, ptr+3 (mod 4); target = first free one; oReady = any channel free. If none is free, target = ptr and oReady=0.
- {oS1,oS0} = target at all times; combinational from state, iMode, iSel and iR0..3.
- Accept (iValid & oReady) at edge N: oZtarget <= iC, oVtarget <= 1, visible in cycle N+1 (latency 1). oCnt <= oCnt+1, wrapping 2^CNT_W-1 -> 0. In iMode=0, ptr <= target+1 mod 4; in iMode=1, ptr is unchanged.
- Simultaneous drain and refill of the same channel: new data is loaded and oVk stays 1 (full throughput, one word per cycle per channel).
- While oVk=1 and iRk=0, oZk and oVk are held stable.
- No accept: ptr, oCnt and all non-draining channels hold.
- Mode or iSel change takes effect in the same cycle's target computation. Already-buffered words are unaffected.
- Combinational path iRk -> oReady/oS* is intentional. Consumers must not drive iRk from oReady.
- Reset mid-operation discards all buffered words; no partial dispatch is counted.

Decomposition:
- Shared package demux14_pkg: channel count constant NCH=4, mode encodings MODE_RR=0 / MODE_FIX=1, and a function rr_pick(free[3:0], ptr[1:0]) returning {found, idx}.
- One natural sub-module: demux14_chan_reg, the per-channel holding register (load, drain, valid/data), instantiated four times. The top holds selection, ptr and counter.

Test Plan:
- Reset: assert iRST_N=0 mid-traffic with oV1=1 -> all oV=0, oZ=0, oCnt=0 immediately; after release with iMode=0 and iR=4'b1111, oReady=1 and {oS1,oS0}=0.
- Round-robin, all consumers ready: iMode=0, iValid=1 for 8 cycles, iC=1,0,1,1,0,0,1,0 -> targets 0,1,2,3,0,1,2,3; each oVk pulses the cycle after its accept; oCnt=8.
- Skip busy channel: ch1 holds a word with iR1=0, others ready, ptr=1 -> next target is 2, then 3, 0, 2 (1 skipped); oZ1/oV1 stable throughout.
- All busy: oV0..3=1, iR=0, iValid=1 -> oReady=0 and {oS1,oS0}=ptr for 5 cycles. Raise iR3 -> target 3 accepted that cycle, ptr becomes 0.
- Fixed mode: iMode=1, iSel=2'b10, iR2 toggling 1,0,1 with iValid=1 -> words land only in ch2; oReady follows free[2]; {oS1,oS0}=2'b10; ptr unchanged.
- Counter wrap with CNT_W=8: 256 accepts -> oCnt returns to 0. Same-cycle drain+refill on ch0 keeps oV0=1 with updated oZ0.
